mem_access_controller: RTL and testbench
========================================

# mem_access_controller

Bus-initiator side of the main-memory port: accepts single-word write and burst-read requests from the CPU datapath (MAR/MBR load logic) and sequences the synchronous, single-port, 1-cycle-latency main memory (addr, data_in, write_enable → registered data_out). It owns every memory-side signal, enforces the memory's read/write timing, bounds-checks addresses against the 16Ki-word array and returns each beat through a valid/ready response channel with backpressure.

## Interface
- ADDR_WIDTH, 16, address width on both sides
- DATA_WIDTH, 16, word width
- MEM_DEPTH, 16384, number of implemented words; addresses ≥ MEM_DEPTH are out of range
- LEN_WIDTH, 4, burst-length field width (beats = req_len+1, max 16)
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE and reset low)
- req_write  in  1  1 = single-word write, 0 = burst read
- req_addr  in  ADDR_WIDTH  start address
- req_len  in  LEN_WIDTH  read beats minus 1; ignored for writes
- req_wdata  in  DATA_WIDTH  write data
- resp_valid  out  1  response beat present
- resp_ready  in  1  consumer accepts beat
- resp_data  out  DATA_WIDTH  read data (0 for write acks and error beats)
- resp_last  out  1  final beat of transaction
- resp_err  out  1  beat address was out of range
- busy  out  1  state ≠ IDLE
- mem_addr  out  ADDR_WIDTH  to memory addr (registered)
- mem_wdata  out  DATA_WIDTH  to memory data_in (registered)
- mem_we  out  1  to memory write_enable (registered)
- mem_rdata  in  DATA_WIDTH  from memory data_out

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_RESP.
- IDLE: req_ready=1. Accept on req_valid&&req_ready edge; latch addr, beat counter = req_len, write flag.
- Read accept: mem_addr←req_addr, mem_we←0 → RD_ISSUE. RD_ISSUE → RD_WAIT unconditionally (memory latches data_out). RD_WAIT: resp_data←mem_rdata, resp_valid←1, resp_last←(counter==0), resp_err←(addr ≥ MEM_DEPTH) → RD_RESP.
- RD_RESP: hold all resp_* stable until resp_ready. On handshake: if last → IDLE, resp_valid←0; else addr+1, counter−1, mem_addr←addr+1, resp_valid←0 → RD_ISSUE.
- Out-of-range read beat: resp_data forced 0, resp_err=1; burst continues, no wrap to 0. Address increment is modulo 2^ADDR_WIDTH; 0xFFFF+1 = 0x0000 (in range, resp_err=0).
- Write accept: if req_addr < MEM_DEPTH, mem_addr←req_addr, mem_wdata←req_wdata, mem_we←1; else mem_we stays 0. → WR_RESP. WR_RESP: mem_we←0 on first cycle; resp_valid=1, resp_last=1, resp_data=0, resp_err=out-of-range; on resp_ready → IDLE.
- mem_we is 1 for exactly one cycle per in-range write and never otherwise.
- Requests arriving while busy are not accepted (req_ready=0); requester must hold them.

## Timing
- Reset (sync): next edge forces IDLE; mem_addr=0, mem_wdata=0, mem_we=0, resp_valid=0, resp_data=0, resp_last=0, resp_err=0, busy=0; req_ready=0 while reset is high. Reset mid-burst discards remaining beats; reset in the cycle mem_we=1 cannot un-write that word (memory samples same edge).
- Read latency: accept at edge E0 → resp_valid high after E2 (2 cycles). Subsequent beats: handshake edge H → next resp_valid after H+2. Sustained: 3 cycles/beat with resp_ready held 1.
- Write: accept E0 → memory written at E1; resp_valid high after E1.
- req_ready returns high the cycle after the final response handshake; back-to-back transactions therefore separated by ≥1 idle cycle.
- Read after write to same address returns new data.

## Test plan
- Reset, then write 0xBEEF to 0x0010 → mem_we high exactly one cycle with mem_addr=0x0010, ack resp_last=1, resp_err=0; read len=0 at 0x0010 → resp_data=0xBEEF, resp_valid 2 cycles after accept.
- Preload 0x0100..0x0103 with 0x1111..0x4444; read len=3, resp_ready=1 → four beats 0x1111..0x4444, 3 cycles apart, resp_last only on the fourth.
- Same burst with resp_ready low 5 cycles on beat 2 → resp_data/resp_last held stable, no beat lost or duplicated, mem_addr unchanged while stalled.
- Write 0x1234 to 0x4000 → mem_we never asserts, ack resp_err=1; read len=2 at 0x3FFF → beat0 real data err=0, beats 1-2 data=0 err=1.
- Read len=1 at 0xFFFF → beat0 err=1 data=0, beat1 address 0x0000 err=0 with memory[0].
- Assert reset during beat 3 of a 16-beat read → next edge resp_valid=0, busy=0, then req_ready=1 after reset drops; new read of 0x0010 returns correct data.

Source files
------------

// File: rtl/mem_access_controller.sv
// Bus-initiator for a synchronous 1-cycle-latency single-port memory: single-word
// writes, incrementing burst reads, bounds checking and a valid/ready response channel.
module mem_access_controller #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 16384,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_last,
    output logic                  resp_err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_RESP} state_t;

    // One extra bit so a depth equal to the full address space still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_last_q, resp_last_d;
    logic                  resp_err_q, resp_err_d;

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} >= DEPTH;
    endfunction

    always_comb begin
        // NOTE: every _d takes its _q value first, so no path through the case leaves
        // a signal unassigned and no latch is inferred.
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = mem_we_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_last_d  = resp_last_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d = req_addr;
                    cnt_d  = req_len;
                    if (req_write) begin
                        if (!out_of_range(req_addr)) begin
                            mem_addr_d  = req_addr;
                            mem_wdata_d = req_wdata;
                            mem_we_d    = 1'b1;
                        end
                        state_d = WR_RESP;
                    end else begin
                        mem_addr_d = req_addr;
                        mem_we_d   = 1'b0;
                        state_d    = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                resp_valid_d = 1'b1;
                resp_last_d  = (cnt_q == '0);
                resp_err_d   = out_of_range(addr_q);
                resp_data_d  = out_of_range(addr_q) ? '0 : mem_rdata;
                state_d      = RD_RESP;
            end
            RD_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    if (resp_last_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d     = addr_q + 1'b1;
                        cnt_d      = cnt_q - 1'b1;
                        mem_addr_d = addr_q + 1'b1;
                        state_d    = RD_ISSUE;
                    end
                end
            end
            WR_RESP: begin
                // The memory has already sampled the write on entry; the ack follows.
                mem_we_d = 1'b0;
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                    resp_last_d  = 1'b1;
                    resp_data_d  = '0;
                    resp_err_d   = out_of_range(addr_q);
                end else if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_last_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_last_q  <= resp_last_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE) && !reset;
    assign busy       = (state_q != IDLE);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_last  = resp_last_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: directed and random writes/burst reads checked
// against a word-level reference image of memory and expected response beats.
module tb_mem_access_controller;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 16384;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [DW-1:0] resp_data;
    logic          resp_last;
    logic          resp_err;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;
    int we_cycles = 0;
    int exp_we = 0;

    logic [DW-1:0] mem_array [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    mem_access_controller #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_last(resp_last), .resp_err(resp_err), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        return 16'(i * 40503 + 23130);
    endfunction

    // Memory device: registered read-first output, 14-bit word index.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem_array[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_we) mem_array[mem_addr[13:0]] <= mem_wdata;
            mem_rdata <= mem_array[mem_addr[13:0]];
        end
    end

    always @(negedge clk) if (mem_we) we_cycles++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_req_ready();
        int k = 0;
        while (!req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_idle", req_ready, 1);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int stall_n);
        logic in_rng;
        in_rng = (addr < DEPTH);
        wait_req_ready();
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
        req_len = LW'($urandom);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = AW'($urandom);
        check("wr_we", mem_we, in_rng);
        if (in_rng) begin
            check("wr_mem_addr", mem_addr, addr);
            check("wr_mem_wdata", mem_wdata, data);
            ref_mem[addr[13:0]] = data;
            exp_we++;
        end
        check("wr_busy", busy, 1);
        check("wr_early_valid", resp_valid, 0);
        @(negedge clk);
        check("wr_we_off", mem_we, 0);
        check("wr_ack_valid", resp_valid, 1);
        check("wr_ack_last", resp_last, 1);
        check("wr_ack_data", resp_data, 0);
        check("wr_ack_err", resp_err, !in_rng);
        if (stall_n > 0) begin
            resp_ready = 1'b0;
            repeat (stall_n) begin
                @(negedge clk);
                check("wr_ack_hold", resp_valid, 1);
            end
            resp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check("wr_done_valid", resp_valid, 0);
        check("wr_done_busy", busy, 0);
        check("wr_done_ready", req_ready, 1);
        check("we_pulses", we_cycles, exp_we);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input int stall_beat, input int stall_n, input int abort_beat);
        logic [AW-1:0] a;
        logic [DW-1:0] exp_data;
        logic          exp_err;
        int            lat;
        wait_req_ready();
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len;
        req_wdata = DW'($urandom);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = AW'($urandom);
        for (int b = 0; b <= int'(len); b++) begin
            a        = addr + AW'(b);
            exp_err  = (a >= DEPTH);
            exp_data = exp_err ? '0 : ref_mem[a[13:0]];
            lat = 1;
            while (!resp_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check("rd_latency", lat, 3);
            if (!resp_valid) return;
            check("rd_mem_addr", mem_addr, a);
            check("rd_data", resp_data, exp_data);
            check("rd_err", resp_err, exp_err);
            check("rd_last", resp_last, (b == int'(len)));
            check("rd_busy", busy, 1);
            if (b == abort_beat) return;
            if (b == stall_beat && stall_n > 0) begin
                resp_ready = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    check("stall_valid", resp_valid, 1);
                    check("stall_data", resp_data, exp_data);
                    check("stall_last", resp_last, (b == int'(len)));
                    check("stall_mem_addr", mem_addr, a);
                end
                resp_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("rd_done_valid", resp_valid, 0);
        check("rd_done_busy", busy, 0);
        check("rd_done_ready", req_ready, 1);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return AW'($urandom);
            1:       return AW'(16'h3FF0 + $urandom_range(0, 31));
            2:       return AW'(16'hFFF0 + $urandom_range(0, 15));
            default: return AW'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_last", resp_last, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_we", mem_we, 0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 1);

        do_write(16'h0010, 16'hBEEF, 0);
        do_read(16'h0010, 4'd0, -1, 0, -1);

        for (int k = 0; k < 4; k++) do_write(AW'(16'h0100 + k), DW'(16'h1111 * (k + 1)), 0);
        do_read(16'h0100, 4'd3, -1, 0, -1);
        do_read(16'h0100, 4'd3, 1, 5, -1);

        do_write(16'h4000, 16'h1234, 2);
        do_read(16'h3FFF, 4'd2, -1, 0, -1);
        do_read(16'hFFFF, 4'd1, -1, 0, -1);

        do_read(16'h0200, 4'd15, -1, 0, 2);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_valid", resp_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_ready_in_rst", req_ready, 0);
        check("abort_mem_addr", mem_addr, 0);
        check("abort_mem_we", mem_we, 0);
        reset = 1'b0;
        #1;
        check("abort_ready", req_ready, 1);
        do_read(16'h0010, 4'd0, -1, 0, -1);

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(rand_addr(), DW'($urandom), $urandom_range(0, 2));
            else
                do_read(rand_addr(), LW'($urandom), $urandom_range(0, 15), $urandom_range(0, 3), -1);
        end

        @(negedge clk);
        check("final_we_pulses", we_cycles, exp_we);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
